// File: rtl/vector_sequencer.sv
// vector_sequencer: replays stored stimulus vectors to a combinational DUT and
// compacts the responses into a MISR signature.
module vector_sequencer #(
    parameter int VEC_WIDTH = 33,
    parameter int RESP_WIDTH = 25,
    parameter int DEPTH = 7,
    parameter logic [RESP_WIDTH-1:0] POLY = RESP_WIDTH'(9),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [VEC_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [AW:0]           vec_len,
    input  logic [15:0]           num_loops,
    output logic [VEC_WIDTH-1:0]  vec_out,
    output logic                  vec_valid,
    input  logic [RESP_WIDTH-1:0] resp_in,
    output logic [RESP_WIDTH-1:0] signature,
    output logic [31:0]           vec_count,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [VEC_WIDTH-1:0] mem [DEPTH];
    logic [VEC_WIDTH-1:0] last_vec_q;
    logic [AW-1:0] idx_q;
    logic [AW:0] len_q;
    logic [15:0] loops_q, loop_q;
    logic [RESP_WIDTH-1:0] sig_q;
    logic [31:0] cnt_q;
    logic aborted_q, run, wrap, last_pass;
    assign run = state_q == RUN;
    assign wrap = {1'b0, idx_q} == len_q - (AW+1)'(1);
    // num_loops of zero never reaches a last pass, so only stop ends the run
    assign last_pass = loops_q != '0 && loop_q == loops_q - 16'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                  state_q == RUN  ? ((stop || (wrap && last_pass)) ? DONE : RUN) : IDLE;
    end
    always_comb begin
        vec_valid = run;
        busy      = run;
        done      = state_q == DONE;
        vec_out   = run ? mem[idx_q] : last_vec_q;
        signature = sig_q;
        vec_count = cnt_q;
        aborted   = aborted_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vec_q <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            loops_q    <= '0;
            loop_q     <= '0;
            sig_q      <= '0;
            cnt_q      <= '0;
            aborted_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            len_q     <= (vec_len == '0 || vec_len > LEN_MAX) ? LEN_MAX : vec_len;
            loops_q   <= num_loops;
            idx_q     <= '0;
            loop_q    <= '0;
            sig_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else if (run) begin
            last_vec_q <= mem[idx_q];
            sig_q      <= (sig_q << 1) ^ resp_in ^ (sig_q[RESP_WIDTH-1] ? POLY : '0);
            cnt_q      <= (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
            idx_q      <= wrap ? '0 : idx_q + AW'(1);
            loop_q     <= wrap ? loop_q + 16'd1 : loop_q;
            if (stop) aborted_q <= 1'b1;
        end
    end
    // Stimulus memory is deliberately left out of reset so a reset keeps the loaded pattern
    always_ff @(posedge clk) begin
        if (wr_en && !run && 32'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: directed runs checked every cycle against a queue of
// expected cycles built from the stored pattern, plus a MISR reference model.
module tb_vector_sequencer;
    localparam logic [24:0] POLY = 25'h0000009;
    logic clk = 0, rst_n = 0, wr_en = 0, start = 0, stop = 0;
    logic [2:0] wr_addr = 0;
    logic [32:0] wr_data = 0;
    logic [3:0] vec_len = 0;
    logic [15:0] num_loops = 0;
    logic [24:0] resp_in = 0;
    logic [32:0] vec_out;
    logic vec_valid, busy, done, aborted;
    logic [24:0] signature;
    logic [31:0] vec_count;

    vector_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .vec_len(vec_len), .num_loops(num_loops),
        .vec_out(vec_out), .vec_valid(vec_valid), .resp_in(resp_in), .signature(signature),
        .vec_count(vec_count), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {logic v; logic [32:0] vec; logic d; logic ab; logic first;} exp_t;
    exp_t q[$];
    logic [32:0] m_mem [7];
    logic [32:0] m_last = 0;
    logic [24:0] m_sig = 0;
    logic [31:0] m_cnt = 0;
    logic m_ab = 0;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] misr(input logic [24:0] s, input logic [24:0] r);
        return (s << 1) ^ r ^ (s[24] ? POLY : 25'h0);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_sig = 0; m_cnt = 0; m_last = 0; m_ab = 0;
        end else begin
            e = '{v: 1'b0, vec: m_last, d: 1'b0, ab: m_ab, first: 1'b0};
            if (q.size() != 0) e = q.pop_front();
            if (e.first) begin m_sig = 0; m_cnt = 0; end
            m_ab = e.ab;
            chk("vec_valid", 64'(vec_valid), 64'(e.v));
            chk("busy", 64'(busy), 64'(e.v));
            chk("done", 64'(done), 64'(e.d));
            chk("aborted", 64'(aborted), 64'(e.ab));
            chk("vec_out", 64'(vec_out), 64'(e.v ? e.vec : m_last));
            chk("signature", 64'(signature), 64'(m_sig));
            chk("vec_count", 64'(vec_count), 64'(m_cnt));
            if (e.v) begin
                m_sig = misr(m_sig, resp_in);
                m_cnt++;
                m_last = e.vec;
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [32:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 0;
        if (a < 7) m_mem[a] = d;
    endtask

    function automatic logic [24:0] gen(input int mode, input int k);
        return mode == 1 ? 25'($urandom) : mode == 2 ? (k == 0 ? 25'h1 : 25'h0) :
               mode == 3 ? (k == 0 ? 25'h1000000 : 25'h0) : 25'h0;
    endfunction

    // stop_at: vector number (1-based) during which stop is raised, 0 = never
    task automatic run(input int len, input int loops, input int stop_at, input int mode,
                       input bit poke, input bit both);
        int eff, natural, total;
        bit ab;
        eff = (len == 0 || len > 7) ? 7 : len;
        natural = loops != 0 ? eff * loops : 1 << 30;
        ab = stop_at != 0 && stop_at <= natural;
        total = ab ? stop_at : natural;
        vec_len = 4'(len); num_loops = 16'(loops); start = 1; stop = both;
        @(posedge clk); #1;
        start = 0; stop = 0;
        for (int k = 0; k < total; k++)
            q.push_back('{v: 1'b1, vec: m_mem[k % eff], d: 1'b0, ab: 1'b0, first: k == 0});
        q.push_back('{v: 1'b0, vec: 33'h0, d: 1'b1, ab: ab, first: 1'b0});
        for (int k = 0; k < total; k++) begin
            resp_in = gen(mode, k);
            start = poke && k == 1;
            wr_en = poke && k == 1; wr_addr = 2; wr_data = {1'b1, $urandom};
            stop = ab && k == total - 1;
            @(posedge clk); #1;
        end
        start = 0; wr_en = 0; stop = 0; resp_in = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("rst_vec_out", 64'(vec_out), 0);
        chk("rst_vec_valid", 64'(vec_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_aborted", 64'(aborted), 0);
        chk("rst_signature", 64'(signature), 0);
        chk("rst_vec_count", 64'(vec_count), 0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 7; i++) wr(3'(i), {1'b0, 32'hA5A50000 + 32'(i * 17)} ^ (33'h1 << (32 - i)));
        run(0, 1, 0, 1, 0, 1);
        chk("lit_count_037", 64'(vec_count), 7);
        chk("lit_aborted_037", 64'(aborted), 0);
        run(3, 4, 0, 1, 0, 0);
        chk("lit_count_038", 64'(vec_count), 12);
        run(0, 0, 20, 1, 0, 0);
        chk("lit_count_039", 64'(vec_count), 20);
        chk("lit_aborted_039", 64'(aborted), 1);
        run(7, 2, 0, 0, 0, 0);
        chk("lit_sig_zero", 64'(signature), 0);
        run(3, 2, 0, 2, 0, 0);
        chk("lit_sig_shift", 64'(signature), 25'h20);
        run(1, 2, 0, 3, 0, 0);
        chk("lit_sig_poly", 64'(signature), 25'h9);
        run(12, 1, 0, 1, 0, 0);
        chk("lit_count_overlen", 64'(vec_count), 7);
        run(3, 3, 0, 1, 1, 0);
        chk("lit_count_poke", 64'(vec_count), 9);
        wr(3'd7, 33'h1FFFFFFFF);
        run(7, 1, 0, 1, 0, 0);
        run(5, 3, 9, 1, 0, 0);
        chk("lit_aborted_last", 64'(aborted), 1);
        vec_len = 5; num_loops = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 4; k++)
            q.push_back('{v: 1'b1, vec: m_mem[k], d: 1'b0, ab: 1'b0, first: k == 0});
        for (int k = 0; k < 4; k++) begin
            resp_in = gen(1, k);
            @(posedge clk); #1;
        end
        rst_n = 0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_valid", 64'(vec_valid), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_count", 64'(vec_count), 0);
        chk("mid_rst_vec_out", 64'(vec_out), 0);
        resp_in = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run(0, 1, 0, 1, 0, 0);
        chk("lit_count_after_rst", 64'(vec_count), 7);
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 33, width of one stimulus vector.
REQ-002 SHALL have parameter RESP_WIDTH, default 25, width of the DUT response word.
REQ-003 SHALL have parameter DEPTH, default 7, number of stimulus memory entries; AW = clog2(DEPTH), minimum 1.
REQ-004 SHALL have parameter POLY, default 25'h0000009, MISR feedback polynomial (RESP_WIDTH bits).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, stimulus memory write strobe.
REQ-008 SHALL have port wr_addr, input, AW, stimulus memory write address.
REQ-009 SHALL have port wr_data, input, VEC_WIDTH, stimulus memory write data.
REQ-010 SHALL have port start, input, 1, one-cycle run request.
REQ-011 SHALL have port stop, input, 1, abort request.
REQ-012 SHALL have port vec_len, input, AW+1, vectors per pass; 0 or >DEPTH means DEPTH.
REQ-013 SHALL have port num_loops, input, 16, pass count; 0 means run until stop.
REQ-014 SHALL have port vec_out, output, VEC_WIDTH, vector driven to DUT.
REQ-015 SHALL have port vec_valid, output, 1, vec_out is being applied this cycle.
REQ-016 SHALL have port resp_in, input, RESP_WIDTH, DUT response.
REQ-017 SHALL have port signature, output, RESP_WIDTH, MISR compaction of responses.
REQ-018 SHALL have port vec_count, output, 32, total vectors applied in current/last run.
REQ-019 SHALL have port busy, output, 1, high in RUN.
REQ-020 SHALL have port done, output, 1, one-cycle pulse at run end.
REQ-021 SHALL have port aborted, output, 1, sticky; last run ended by stop.

Function
REQ-022 SHALL implement states IDLE, RUN, DONE.
REQ-023 SHALL in IDLE on start: latch effective length and num_loops, clear index, loop counter, vec_count, signature and aborted, go RUN.
REQ-024 SHALL in RUN: vec_out = mem[index], vec_valid = 1, busy = 1, one vector per cycle, first vector in cycle after start.
REQ-025 SHALL sample resp_in on every rising edge where vec_valid is 1 (same cycle as its vector, combinational DUT).
REQ-026 SHALL update signature = (signature << 1) ^ resp_in ^ (signature[MSB] ? POLY : 0) per sampled response.
REQ-027 SHALL increment vec_count per applied vector, saturating at 2^32-1.
REQ-028 SHALL wrap index from length-1 to 0 and increment loop counter at each wrap.
REQ-029 SHALL go DONE after the last vector of pass num_loops (num_loops != 0); never for num_loops = 0.
REQ-030 SHALL on stop in RUN: current vector still applied and sampled, set aborted, go DONE next cycle.
REQ-031 SHALL in DONE: pulse done for one cycle, vec_valid = 0, go IDLE.
REQ-032 SHALL ignore start outside IDLE; stop outside RUN; start and stop both in IDLE -> start wins.
REQ-033 SHALL write memory on wr_en only outside RUN; writes in RUN dropped; wr_addr >= DEPTH dropped.
REQ-034 SHALL hold vec_out at last applied vector when vec_valid = 0; signature and vec_count held until next start.

Reset
REQ-035 SHALL on rst_n low, immediately: state IDLE, vec_out 0, vec_valid 0, signature 0, vec_count 0, busy 0, done 0, aborted 0.
REQ-036 SHALL not reset stimulus memory; reset mid-RUN aborts without done pulse.

Verification
REQ-037 SHALL cover: load 7 vectors, vec_len=0, num_loops=1, start -> mem[0..6] on 7 consecutive cycles, done pulse 1 cycle after last, vec_count=7.
REQ-038 SHALL cover: vec_len=3, num_loops=4 -> sequence 0,1,2 x4, vec_count=12, signature equals reference model over 12 responses.
REQ-039 SHALL cover: num_loops=0, stop after 20 vectors -> vec_count=20 (stop vector included), aborted=1, done pulse.
REQ-040 SHALL cover: wr_en to addr 2 during RUN -> mem[2] unchanged in next pass; wr_addr=7 in IDLE dropped.
REQ-041 SHALL cover: resp_in=0 all cycles -> signature 0; resp_in=1 one cycle then 0 -> signature 1 shifted per later vector.
REQ-042 SHALL cover: rst_n low mid-run -> busy 0, vec_valid 0 same cycle, no done; memory contents preserved for next start.
